// File: rtl/secure_crypto_pkg.sv
// Shared types, constants and rotate helpers for the XOR/rotate block cipher.
package secure_crypto_pkg;

    localparam int DATA_W = 128;
    localparam int KEY_W  = 2 * DATA_W;

    localparam logic [DATA_W-1:0] RK_CONST_EVEN = {16{8'hA5}};
    localparam logic [DATA_W-1:0] RK_CONST_ODD  = {16{8'h5A}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dec_state_t;

    // Rotate left by amt (0..127); the doubled vector makes amt = 0 a plain pass-through.
    function automatic logic [DATA_W-1:0] rotl128(input logic [DATA_W-1:0] x,
                                                  input logic [6:0]        amt);
        logic [2*DATA_W-1:0] tmp;
        tmp = {x, x} << amt;
        return tmp[2*DATA_W-1:DATA_W];
    endfunction

    // Rotate right by amt (0..127).
    function automatic logic [DATA_W-1:0] rotr128(input logic [DATA_W-1:0] x,
                                                  input logic [6:0]        amt);
        logic [2*DATA_W-1:0] tmp;
        tmp = {x, x} >> amt;
        return tmp[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/decrypt_round_key_gen.sv
// Combinational round-key generator. The only place where the two key shares
// are recombined, so the plain key never exists in a register.
module decrypt_round_key_gen
    import secure_crypto_pkg::*;
(
    input  logic [KEY_W-1:0]  share0,
    input  logic [KEY_W-1:0]  share1,
    input  logic [3:0]        rnd,
    output logic [DATA_W-1:0] rk
);

    logic [KEY_W-1:0] key;
    logic [6:0]       amt;

    // Recombine shares and pick the half/constant/rotation for this round.
    // NOTE: every output of an always_comb is assigned on every path; a missing branch would infer a latch.
    always_comb begin
        key = share0 ^ share1;
        amt = {rnd, 3'b000};
        if (rnd[0]) begin
            rk = rotl128(key[DATA_W-1:0] ^ RK_CONST_ODD, amt);
        end else begin
            rk = rotl128(key[KEY_W-1:DATA_W] ^ RK_CONST_EVEN, amt);
        end
    end

endmodule

// File: rtl/secure_decrypt_core.sv
// Masked-key decrypt core: one inverse round per clock, valid/ready on both
// sides, with key lock and zeroize.
module secure_decrypt_core
    import secure_crypto_pkg::*;
#(
    parameter int NUM_ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  key_in,
    input  logic [KEY_W-1:0]  mask_in,
    input  logic              key_lock,
    input  logic              zeroize,
    output logic              key_present,
    output logic              key_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out
);

    logic [KEY_W-1:0]  share0;
    logic [KEY_W-1:0]  share1;
    logic              locked;
    dec_state_t        state;
    logic [3:0]        rnd;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] rk;

    decrypt_round_key_gen u_rk_gen (
        .share0 (share0),
        .share1 (share1),
        .rnd    (rnd),
        .rk     (rk)
    );

    // Key storage, lock, and the decrypt FSM with its registered handshake outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            // NOTE: key shares are explicitly cleared; leaving secret material undefined after reset/zeroize is not acceptable.
            share0      <= '0;
            share1      <= '0;
            key_present <= 1'b0;
            locked      <= 1'b0;
            key_err     <= 1'b0;
            state       <= IDLE;
            rnd         <= '0;
            work        <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            key_err <= 1'b0;

            // Key load: refused while locked, silently ignored outside IDLE.
            if (key_load) begin
                if (locked) begin
                    key_err <= 1'b1;
                end else if (state == IDLE) begin
                    share0      <= key_in ^ mask_in;
                    share1      <= mask_in;
                    key_present <= 1'b1;
                end
            end

            // Lock applies after any same-cycle load because the load tested the old value.
            if (key_lock) begin
                locked <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= data_in;
                        rnd      <= 4'(NUM_ROUNDS - 1);
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= key_present || (key_load && !locked);
                    end
                end
                RUN: begin
                    work <= rotr128(work, 7'd1) ^ rk;
                    if (rnd == 4'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        work      <= '0;
                        state     <= IDLE;
                        in_ready  <= key_present;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = out_valid ? work : '0;

endmodule

// File: tb/tb_secure_decrypt_core.sv
// Self-checking bench: random keys/masks/plaintexts, encrypted by a behavioural
// model, fed through the core and compared against the original plaintext.
module tb_secure_decrypt_core;
    import secure_crypto_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_load;
    logic [KEY_W-1:0]  key_in;
    logic [KEY_W-1:0]  mask_in;
    logic              key_lock;
    logic              zeroize;
    logic              in_valid;
    logic              in_valid1;
    logic [DATA_W-1:0] data_in;
    logic              out_ready;
    logic              key_present, key_err, in_ready, out_valid;
    logic [DATA_W-1:0] data_out;
    logic              key_present1, key_err1, in_ready1, out_valid1;
    logic [DATA_W-1:0] data_out1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    secure_decrypt_core #(.NUM_ROUNDS(4)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .mask_in(mask_in),
        .key_lock(key_lock), .zeroize(zeroize), .key_present(key_present), .key_err(key_err),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
    );

    secure_decrypt_core #(.NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .mask_in(mask_in),
        .key_lock(key_lock), .zeroize(zeroize), .key_present(key_present1), .key_err(key_err1),
        .in_valid(in_valid1), .in_ready(in_ready1), .data_in(data_in),
        .out_valid(out_valid1), .out_ready(out_ready), .data_out(data_out1)
    );

    task automatic check(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [127:0] m_rotl(input logic [127:0] x, input int n);
        int k;
        k = n % 128;
        if (k == 0) return x;
        return (x << k) | (x >> (128 - k));
    endfunction

    function automatic logic [127:0] m_rk(input logic [255:0] key, input int i);
        if (i % 2 == 0) return m_rotl(key[255:128] ^ {16{8'hA5}}, 8 * i);
        else            return m_rotl(key[127:0]   ^ {16{8'h5A}}, 8 * i);
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [255:0] key, input logic [127:0] p, input int n);
        logic [127:0] x;
        x = p;
        for (int i = 0; i < n; i++) x = m_rotl(x ^ m_rk(key, i), 1);
        return x;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [255:0] k, input logic [255:0] m);
        key_in   = k;
        mask_in  = m;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        mask_in  = rand256();
        tick();
    endtask

    // Encrypt p with the model, push the ciphertext, stall the output, then drain.
    task automatic do_block(input string tag, input logic [255:0] k, input logic [127:0] p, input int stalls);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        check({tag, "_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        data_in  = m_encrypt(k, p, 4);
        tick();
        in_valid = 1'b0;
        data_in  = rand128();
        check({tag, "_busy"}, in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_pt"}, data_out, p);
        for (int s = 0; s < stalls; s++) begin
            tick();
            check({tag, "_hold"}, {out_valid, data_out}, {1'b1, p});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain"}, {out_valid, data_out}, '0);
    endtask

    logic [255:0] k_a, k_b, m_a, m_b;
    logic [127:0] p;
    int           lat;
    logic         seen;

    initial begin
        rst = 1'b1; key_load = 1'b0; key_in = '0; mask_in = '0; key_lock = 1'b0;
        zeroize = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; data_in = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check("rst_outs", {out_valid, in_ready, key_present, key_err, data_out}, '0);
        check("rst_shares", dut.share0 | dut.share1, '0);
        check("rst_state", dut.state == IDLE, 1'b1);

        // No key: ciphertext is not accepted.
        in_valid = 1'b1;
        data_in  = rand128();
        for (int i = 0; i < 5; i++) tick();
        check("nokey_ready", in_ready, 1'b0);
        check("nokey_state", {dut.state == IDLE, out_valid}, 2'b10);
        in_valid = 1'b0;

        // Same-cycle zeroize + key_load: zeroize wins.
        key_in = rand256(); mask_in = rand256();
        key_load = 1'b1; zeroize = 1'b1;
        tick();
        key_load = 1'b0; zeroize = 1'b0;
        tick();
        check("zl_present", key_present, 1'b0);
        check("zl_share0", dut.share0, '0);

        // NUM_ROUNDS=1, zero key: 4B.. decrypts to 0 after one edge.
        load_key('0, rand256());
        in_valid1 = 1'b1;
        data_in   = {16{8'h4B}};
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 10) begin tick(); lat++; end
        check("n1_lat", lat, 1);
        check("n1_pt", data_out1, '0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("n1_drain", out_valid1, 1'b0);

        // Same key, two masks: different shares, same plaintext, plain key never stored.
        k_a = rand256(); m_a = rand256(); m_b = rand256();
        p   = rand128();
        load_key(k_a, m_a);
        check("mask1_share0", dut.share0, k_a ^ m_a);
        check("mask1_share1", dut.share1, m_a);
        check("mask1_nokey", (dut.share0 != k_a) && (dut.share1 != k_a), 1'b1);
        do_block("mask1", k_a, p, 1);
        load_key(k_a, m_b);
        check("mask2_share0", dut.share0, k_a ^ m_b);
        check("mask2_nokey", (dut.share0 != k_a) && (dut.share1 != k_a), 1'b1);
        check("mask_idle_change", dut.share1, m_b);
        do_block("mask2", k_a, p, 0);

        // 100 random blocks with back-pressure; key refreshed every 20 blocks.
        for (int b = 0; b < 100; b++) begin
            if (b % 20 == 0) begin
                k_a = rand256();
                load_key(k_a, rand256());
            end
            do_block("rand", k_a, rand128(), int'($urandom_range(0, 3)));
        end

        // Zeroize during RUN with rnd == 2: block discarded.
        while (!in_ready) tick();
        in_valid = 1'b1;
        data_in  = m_encrypt(k_a, rand128(), 4);
        tick();
        in_valid = 1'b0;
        tick();
        check("zr_rnd", dut.rnd, 4'd2);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zr_state", dut.state == IDLE, 1'b1);
        check("zr_outs", {out_valid, data_out, key_present, in_ready}, '0);
        seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin tick(); seen |= out_valid; end
        out_ready = 1'b0;
        check("zr_no_output", seen, 1'b0);

        // Lock + load in the same cycle: load applies, then lock holds.
        k_a = rand256(); k_b = rand256();
        key_in = k_a; mask_in = rand256(); key_load = 1'b1; key_lock = 1'b1;
        tick();
        key_load = 1'b0; key_lock = 1'b0;
        check("lk_loaded", dut.share0 ^ dut.share1, k_a);
        check("lk_locked", dut.locked, 1'b1);
        key_in = k_b; mask_in = rand256(); key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("lk_err_pulse", key_err, 1'b1);
        tick();
        check("lk_err_clear", key_err, 1'b0);
        do_block("lk_oldkey", k_a, rand128(), 2);

        // Zeroize clears the lock; a new load then succeeds.
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zz_state", {key_present, in_ready, dut.locked}, 3'b000);
        load_key(k_b, rand256());
        check("zz_reload", {key_present, key_err}, 2'b10);
        do_block("zz_newkey", k_b, rand128(), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/secure_decrypt_core.md
Name: secure_decrypt_core

Overview:
- Receive-side counterpart of the crypto datapath.
- Recovers 128-bit plaintext from ciphertext produced by the team's multi-round XOR/rotate cipher, one round per clock.
- Holds the 256-bit key only as two masked shares. Supports lock and zeroize.
- Uses valid/ready handshakes so it can sit between the bus unpacker and the payload consumer.

Parameters:
NUM_ROUNDS, 4, cipher rounds (1..15); round index is 4 bits
DATA_W, 128, block width (fixed; KEY_W = 2*DATA_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_load  in  1  one-cycle strobe; capture key_in
key_in  in  256  secret key {K_hi, K_lo}
mask_in  in  256  fresh random mask from TRNG, sampled with key_load
key_lock  in  1  strobe; set lock, blocks further key_load
zeroize  in  1  strobe; clear key shares, lock, datapath
key_present  out  1  a key is loaded
key_err  out  1  one-cycle pulse: key_load while locked
in_valid  in  1  ciphertext valid
in_ready  out  1  core can accept ciphertext
data_in  in  128  ciphertext
out_valid  out  1  plaintext valid
out_ready  in  1  consumer accepts plaintext
data_out  out  128  plaintext; forced 0 whenever out_valid=0

Behaviour:
- Reset: all of the following clear to 0:
  - share0, share1, key_present, locked, key_err
  - state=IDLE, round counter, working register
  - out_valid=0, data_out=0, in_ready=0
- Key storage:
  - On key_load with !locked: share0 <= key_in ^ mask_in; share1 <= mask_in; key_present <= 1.
  - On key_load with locked: shares unchanged; key_err pulses for one cycle.
  - Plain key is never registered. The effective key is share0 ^ share1, formed combinationally only inside round-key generation.
  - key_load is honoured only in IDLE. In RUN or DONE it is ignored; key_err pulses if locked.
- Lock: key_lock sets locked. Only rst or zeroize clears it.
- Round keys, for i in 0..NUM_ROUNDS-1:
  - i even: rk_i = rotl128(K_hi ^ {16{8'hA5}}, 8*i)
  - i odd: rk_i = rotl128(K_lo ^ {16{8'h5A}}, 8*i)
  - Rotation amount is taken mod 128.
- Cipher definition (encrypt side): x0 = P; x_{i+1} = rotl128(x_i ^ rk_i, 1); C = x_N.
- Decrypt: y_N = C; y_i = rotr128(y_{i+1}, 1) ^ rk_i for i = N-1 down to 0; P = y_0.
- FSM:
  - IDLE: in_ready = key_present.
    - On in_valid & in_ready: work <= data_in; rnd <= NUM_ROUNDS-1; go to RUN.
    - in_valid with no key: not accepted; in_ready stays 0.
  - RUN: each cycle work <= rotr(work,1) ^ rk_rnd.
    - When rnd == 0, go to DONE and set out_valid=1.
    - Otherwise rnd decrements.
  - DONE: data_out = work while out_valid.
    - On out_ready: out_valid <= 0; work <= 0; go to IDLE.
    - Output holds stable while out_ready=0.
- Latency: out_valid first high NUM_ROUNDS clock edges after the accepting edge. Throughput is one block per NUM_ROUNDS+2 cycles minimum.
- in_ready is 0 in RUN and DONE; there is no overlap.
- Zeroize (any state, highest priority after rst):
  - shares, key_present, locked, work, rnd cleared; out_valid=0; state=IDLE.
  - An in-flight block is discarded.
  - zeroize and key_load in the same cycle: zeroize wins; the key is not loaded.
- key_lock and key_load in the same cycle: the load applies (lock not yet set), then lock takes effect.
- Changing mask_in at any time other than key_load has no effect.

Decomposition:
- Package secure_crypto_pkg holds:
  - DATA_W and KEY_W
  - RK_CONST_EVEN = {16{8'hA5}} and RK_CONST_ODD = {16{8'h5A}}
  - FSM state enum {IDLE, RUN, DONE}
  - rotl128/rotr128 functions
- Sub-module: decrypt_round_key_gen. It is combinational: shares plus round index in, rk out. This isolates share recombination.

Test Plan:
1. NUM_ROUNDS=1, key_in = 0, mask_in = random; data_in = 128'h4B4B…4B -> out_valid after 1 edge with data_out = 0.
2. Default N=4, random key/mask/plaintext: encrypt with the bench model, feed C -> data_out = P after 4 edges. Repeat 100 blocks with random out_ready back-pressure; data_out stays stable while stalled.
3. Two loads of the same key with different masks -> identical plaintext, different share0 values. No internal register ever equals key_in.
4. key_lock then key_load with a new key -> key_err pulses once; decrypt still uses the old key. zeroize -> key_present=0, in_ready=0, lock cleared; a subsequent load succeeds.
5. zeroize asserted during RUN round 2 -> next cycle state=IDLE, out_valid=0, data_out=0; no plaintext emitted.
6. in_valid with no key after rst -> in_ready=0, nothing accepted. Same-cycle zeroize+key_load -> key_present stays 0.
